// File: rtl/tage_component_table_if.sv
// Lookup/update bus of one TAGE prediction component.
//   master : drives the pre-hashed index/tag and the resolved-branch update
//   slave  : the table; returns prediction_o / tag_hit_o for the latched entry
// Signals:
//   hash_idx_i, hash_tag_i                       lookup index / tag (latched each cycle)
//   update_valid_i, br_result_i, provider_i,
//   update_u_i, alloc_i                          update for the latched entry
//   prediction_o, tag_hit_o                      lookup result of the latched entry
interface tage_component_table_if #(
  parameter int IDX_W = 9,
  parameter int TAG_W = 10
);
  logic [IDX_W-1:0] hash_idx_i;
  logic [TAG_W-1:0] hash_tag_i;
  logic             update_valid_i;
  logic             br_result_i;
  logic             provider_i;
  logic             update_u_i;
  logic             alloc_i;
  logic             prediction_o;
  logic             tag_hit_o;

  modport master (
    output hash_idx_i, hash_tag_i, update_valid_i, br_result_i,
           provider_i, update_u_i, alloc_i,
    input  prediction_o, tag_hit_o
  );

  modport slave (
    input  hash_idx_i, hash_tag_i, update_valid_i, br_result_i,
           provider_i, update_u_i, alloc_i,
    output prediction_o, tag_hit_o
  );
endinterface

// File: rtl/tage_component_table.sv
// One TAGE prediction component: tagged table (TAGGED=1) or bimodal base
// table (TAGGED=0), 2^IDX_W entries.
// Ports:
//   clk_i  clock, all state on the rising edge
//   rst_i  asynchronous active-high reset
//   bus    tage_component_table_if.slave (lookup index/tag, resolved-branch
//          update, prediction_o / tag_hit_o of the latched entry)
// Lookup: index/tag are latched every edge; outputs are combinational from
// the entry at the latched index, so they follow the index by one cycle.
// Updates always target the latched entry and land at the same edge that
// latches the next index.
// Optional build macro TAGE_U_RESET_EN (tagged only): periodic useful-bit
// aging, one step every 2^U_RESET_LOG2 updates, alternately clearing u[1]
// then u[0] in all entries.
module tage_component_table #(
  parameter int TAGGED       = 1,
  parameter int IDX_W        = 9,
  parameter int TAG_W        = 10,
  parameter int U_RESET_LOG2 = 18
) (
  input logic                  clk_i,
  input logic                  rst_i,
  tage_component_table_if.slave bus
);

  localparam int DEPTH = 1 << IDX_W;

  if (U_RESET_LOG2 < 1) begin : g_bad_ulog
    $error("U_RESET_LOG2 must be at least 1");
  end

  logic [IDX_W-1:0] lat_idx;
  logic [TAG_W-1:0] lat_tag;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_idx <= '0;
      lat_tag <= '0;
    end else begin
      lat_idx <= bus.hash_idx_i;
      lat_tag <= bus.hash_tag_i;
    end
  end

  if (TAGGED != 0) begin : g_tagged
    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q;
    logic [DEPTH-1:0][2:0]       ctr_q;
    logic [DEPTH-1:0][1:0]       u_q;

    logic       hit, pred;
    logic [2:0] ctr_cur, ctr_inc, ctr_dec;
    logic [1:0] u_cur, u_inc, u_dec;
    logic       age;      // aging step happens at this edge
    logic       age_bit;  // which u bit the aging step clears

    assign ctr_cur = ctr_q[lat_idx];
    assign u_cur   = u_q[lat_idx];
    assign hit     = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);
    assign pred    = ctr_cur[2];
    assign ctr_inc = (ctr_cur == 3'd7) ? ctr_cur : ctr_cur + 3'd1;
    assign ctr_dec = (ctr_cur == 3'd0) ? ctr_cur : ctr_cur - 3'd1;
    assign u_inc   = (u_cur == 2'd3) ? u_cur : u_cur + 2'd1;
    assign u_dec   = (u_cur == 2'd0) ? u_cur : u_cur - 2'd1;

    assign bus.prediction_o = pred;
    assign bus.tag_hit_o    = hit;

`ifdef TAGE_U_RESET_EN
    logic [U_RESET_LOG2-1:0] age_cnt;
    logic                    age_phase;

    // Aging fires on the update that wraps the counter.
    assign age     = bus.update_valid_i && (&age_cnt);
    assign age_bit = ~age_phase;  // phase 0 clears u[1], phase 1 clears u[0]

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        age_cnt   <= '0;
        age_phase <= 1'b0;
      end else if (bus.update_valid_i) begin
        age_cnt <= age_cnt + U_RESET_LOG2'(1);
        if (age) age_phase <= ~age_phase;
      end
    end
`else
    assign age     = 1'b0;
    assign age_bit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          valid_q[i] <= 1'b0;
          tag_q[i]   <= '0;
          ctr_q[i]   <= 3'd3;
          u_q[i]     <= 2'd0;
        end
      end else begin
        if (bus.update_valid_i) begin
          if (bus.provider_i) begin
            // Provider path wins over allocation; misses leave the entry alone.
            if (hit) begin
              ctr_q[lat_idx] <= bus.br_result_i ? ctr_inc : ctr_dec;
              if (bus.update_u_i && !age)
                u_q[lat_idx] <= (pred == bus.br_result_i) ? u_inc : u_dec;
            end
          end else if (bus.alloc_i) begin
            if (u_cur == 2'd0) begin
              // u is already 0 here, so the new entry starts with u=0.
              valid_q[lat_idx] <= 1'b1;
              tag_q[lat_idx]   <= lat_tag;
              ctr_q[lat_idx]   <= bus.br_result_i ? 3'd4 : 3'd3;
            end else if (!age) begin
              // Refused allocation ages the victim instead.
              u_q[lat_idx] <= u_dec;
            end
          end
        end
        // Aging takes priority: u updates above are suppressed in this edge.
        if (age) begin
          for (int i = 0; i < DEPTH; i++) u_q[i][age_bit] <= 1'b0;
        end
      end
    end
  end else begin : g_bimodal
    logic [DEPTH-1:0][1:0] ctr_q;
    logic [1:0]            ctr_cur;

    assign ctr_cur          = ctr_q[lat_idx];
    assign bus.prediction_o = ctr_cur[1];
    assign bus.tag_hit_o    = 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) ctr_q[i] <= 2'b01;
      end else if (bus.update_valid_i) begin
        if (bus.br_result_i)
          ctr_q[lat_idx] <= (ctr_cur == 2'd3) ? ctr_cur : ctr_cur + 2'd1;
        else
          ctr_q[lat_idx] <= (ctr_cur == 2'd0) ? ctr_cur : ctr_cur - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_tage_component_table.sv
module tb_tage_component_table;
  localparam int IDX_W = 9;
  localparam int TAG_W = 10;

  typedef struct {
    string name;
    logic  p;
    logic  h;
    bit    bim;
  } exp_t;

  logic clk, rst;
  int   vectors = 0;
  int   errs    = 0;
  exp_t sb[$];

  tage_component_table_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bt ();
  tage_component_table_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bb ();

  tage_component_table #(.TAGGED(1), .IDX_W(IDX_W), .TAG_W(TAG_W), .U_RESET_LOG2(2)) u_tag (
    .clk_i(clk), .rst_i(rst), .bus(bt)
  );
  tage_component_table #(.TAGGED(0), .IDX_W(IDX_W), .TAG_W(TAG_W), .U_RESET_LOG2(2)) u_bim (
    .clk_i(clk), .rst_i(rst), .bus(bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", n, obs, exp);
    end
  endtask

  task automatic et(input string n, input logic p, input logic h);
    exp_t e;
    e.name = n; e.p = p; e.h = h; e.bim = 1'b0;
    sb.push_back(e);
  endtask

  task automatic eb(input string n, input logic p, input logic h);
    exp_t e;
    e.name = n; e.p = p; e.h = h; e.bim = 1'b1;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.bim) begin
        chk({e.name, "_bim_pred"}, bb.prediction_o, e.p);
        chk({e.name, "_bim_hit"},  bb.tag_hit_o,    e.h);
      end else begin
        chk({e.name, "_pred"}, bt.prediction_o, e.p);
        chk({e.name, "_hit"},  bt.tag_hit_o,    e.h);
      end
    end
  endtask

  task automatic drive(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                       input logic uv, input logic br, input logic prov,
                       input logic uu, input logic al);
    bt.hash_idx_i = idx;  bb.hash_idx_i = idx;
    bt.hash_tag_i = tag;  bb.hash_tag_i = tag;
    bt.update_valid_i = uv;  bb.update_valid_i = uv;
    bt.br_result_i = br;     bb.br_result_i = br;
    bt.provider_i = prov;    bb.provider_i = prov;
    bt.update_u_i = uu;      bb.update_u_i = uu;
    bt.alloc_i = al;         bb.alloc_i = al;
  endtask

  // Called at a falling edge: drive, take the rising edge, check, return at falling edge.
  task automatic step(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                      input logic uv, input logic br, input logic prov,
                      input logic uu, input logic al);
    drive(idx, tag, uv, br, prov, uu, al);
    @(posedge clk);
    #1;
    drain();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    drive('0, '0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef TAGE_U_RESET_EN
  // Counter wraps on updates 4,8,12,16 (phase 0,1,0,1). u reaches 3 by
  // update 11; update 12 clears u[1] -> 1; update 16 clears u[0] -> 0.
  task automatic aging_run(input bit second);
    logic [TAG_W-1:0] ta, tb_;
    ta = 10'h155; tb_ = 10'h0AA;
    reset_pulse();
    et("age_pre", 0, 0);      step(12, ta, 0, 0, 0, 0, 0);
    et("age_alloc", 1, 1);    step(12, ta, 1, 1, 0, 0, 1);   // update 1
    for (int i = 2; i <= 8; i++) begin
      et("age_fill", 1, 1);   step(12, ta, 1, 1, 1, 0, 0);
    end
    for (int i = 9; i <= 11; i++) begin
      et("age_u_up", 1, 1);   step(12, ta, 1, 1, 1, 1, 0);
    end
    et("age_wrap0", 1, 0);    step(12, tb_, 1, 1, 1, 0, 0);  // update 12
    if (!second) begin
      et("age_u1_refuse", 1, 0); step(12, tb_, 1, 1, 0, 0, 1);
      et("age_u1_alloc", 1, 1);  step(12, tb_, 1, 1, 0, 0, 1);
    end else begin
      for (int i = 13; i <= 16; i++) begin
        et("age_fill2", 1, 0);   step(12, tb_, 1, 1, 1, 0, 0);
      end
      et("age_u0_alloc", 1, 1);  step(12, tb_, 1, 1, 0, 0, 1);
    end
  endtask
`endif

  initial begin
    logic [1:0] bctr;
    logic [2:0] mctr;
    rst = 1'b1;
    drive('0, '0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) step(IDX_W'($urandom_range(0, 511)), '0, 0, 0, 0, 0, 0);

    // Reset mid-run with idx=5 presented: async, visible before any edge.
    drive(5, '0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    et("rst_async", 0, 0); eb("rst_async", 0, 1);
    drain();
    @(posedge clk);
    #1;
    et("rst_held", 0, 0); eb("rst_held", 0, 1);
    drain();
    @(negedge clk);
    rst = 1'b0;

    // Bimodal training on idx 7 (ctr starts at 1).
    bctr = 2'd1;
    et("t_idx7", 0, 0); eb("b_idx7", bctr[1], 1);
    step(7, '0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      bctr = (bctr == 2'd3) ? bctr : bctr + 2'd1;
      eb("b_taken", bctr[1], 1);
      step(7, '0, 1, 1, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      bctr = (bctr == 2'd0) ? bctr : bctr - 2'd1;
      eb("b_ntaken", bctr[1], 1);
      step(7, '0, 1, 0, 0, 0, 0);
    end
    eb("b_floor", 0, 1);
    step(7, '0, 0, 0, 0, 0, 0);

    // Allocation on idx 12, tag 0x2A5, taken.
    et("pre_alloc", 0, 0);        step(12, 10'h2A5, 0, 0, 0, 0, 0);
    et("alloc_hit", 1, 1);        step(12, 10'h2A5, 1, 1, 0, 0, 1);
    et("alloc_other_tag", 1, 0);  step(12, 10'h2A4, 0, 0, 0, 0, 0);
    et("alloc_relook", 1, 1);     step(12, 10'h2A5, 0, 0, 0, 0, 0);

    // Provider counter: 4 -> 3 -> 2, then saturate at 7.
    mctr = 3'd4;
    for (int i = 0; i < 2; i++) begin
      mctr = mctr - 3'd1;
      et("prov_nt", mctr[2], 1);  step(12, 10'h2A5, 1, 0, 1, 0, 0);
    end
    for (int i = 0; i < 6; i++) begin
      mctr = (mctr == 3'd7) ? mctr : mctr + 3'd1;
      et("prov_t", mctr[2], 1);   step(12, 10'h2A5, 1, 1, 1, 0, 0);
    end
    // Provider miss: ctr must not move (stays 7 -> prediction 1 on relookup).
    et("miss_tag", 1, 0);         step(12, 10'h001, 0, 0, 0, 0, 0);
    et("miss_upd", 1, 1);         step(12, 10'h2A5, 1, 0, 1, 0, 0);

`ifdef TAGE_U_RESET_EN
    aging_run(1'b0);
    aging_run(1'b1);
`else
    // Useful bits: 4 correct provider updates saturate u at 3; then
    // exactly three refused allocations are needed before one succeeds.
    for (int i = 0; i < 4; i++) begin
      et("u_train", 1, 1);        step(12, 10'h2A5, 1, 1, 1, 1, 0);
    end
    et("u_new_tag", 1, 0);        step(12, 10'h111, 0, 0, 0, 0, 0);
    et("alloc_refused", 1, 0);    step(12, 10'h111, 1, 0, 0, 0, 1);
    et("tag_kept", 1, 1);         step(12, 10'h2A5, 0, 0, 0, 0, 0);
    et("u_new_tag2", 1, 0);       step(12, 10'h111, 0, 0, 0, 0, 0);
    et("refuse_u2", 1, 0);        step(12, 10'h111, 1, 0, 0, 0, 1);
    et("refuse_u1", 1, 0);        step(12, 10'h111, 1, 0, 0, 0, 1);
    et("alloc_ok", 0, 1);         step(12, 10'h111, 1, 0, 0, 0, 1);
`endif

    // Untouched entry still at reset state.
    et("fresh_idx", 0, 0); eb("fresh_idx", 0, 1);
    step(300, 10'h3FF, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tage_component_table.md
Name: tage_component_table

Overview:
- One prediction component of the TAGE branch predictor: either a tagged table (T1..T4) or the untagged bimodal base table (T0), selected by parameter TAGGED.
- Holds 2^IDX_W entries and is looked up with a pre-hashed index (and tag).
- Returns a taken/not-taken prediction plus tag hit, then updates counters, useful bits and allocations from the resolved branch outcome supplied by the predictor top.

Parameters:
- TAGGED, 1: 1 = tagged table; 0 = bimodal base table (no tag, no useful bits, 2-bit counter).
- IDX_W, 9: index width; table depth = 2^IDX_W entries.
- TAG_W, 10: tag width (ignored when TAGGED=0).
- U_RESET_LOG2, 18: log2 of the update count between useful-bit aging steps (used only with the optional feature).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- hash_idx_i  in  IDX_W  lookup index, latched every cycle.
- hash_tag_i  in  TAG_W  lookup tag, latched every cycle.
- update_valid_i  in  1  resolved branch present this cycle for the latched entry.
- br_result_i  in  1  resolved outcome, 1 = taken.
- provider_i  in  1  this table was the final provider.
- update_u_i  in  1  provider prediction differed from alternate prediction.
- alloc_i  in  1  allocate the latched entry (tagged only).
- prediction_o  out  1  predicted direction of the latched entry.
- tag_hit_o  out  1  latched entry valid and tag equal.

Behaviour:
- Entry fields, TAGGED=1: valid (1b), tag (TAG_W), ctr (3b unsigned), u (2b).
- Entry fields, TAGGED=0: ctr (2b) only.
- Reset (asynchronous, takes effect immediately, mid-operation included):
  - all entries: valid=0, tag=0, u=0.
  - ctr=3'd3 (weak not-taken), or 2'b01 for the bimodal table.
  - lookup registers cleared to 0.
  - outputs: prediction_o=0, tag_hit_o=0 (bimodal: tag_hit_o=1).
- Lookup timing:
  - At each rising edge, hash_idx_i and hash_tag_i are latched (lat_idx, lat_tag).
  - prediction_o and tag_hit_o are combinational from the storage at lat_idx, so they are valid one cycle after the index is presented.
- Prediction:
  - tagged: prediction_o = ctr[2] (taken when ctr >= 4).
  - bimodal: prediction_o = ctr[1].
- Tag hit:
  - tagged: tag_hit_o = valid & (tag == lat_tag).
  - bimodal: tag_hit_o is constant 1.
- Update is applied at the rising edge in which update_valid_i=1, always to entry lat_idx:
  - Bimodal: ctr saturating +1 if taken, -1 if not taken (0..3), every valid update, regardless of provider_i.
  - Tagged, provider_i=1 and tag hit: ctr saturating +1/-1 (0..7).
  - Tagged, provider_i=1 and update_u_i=1: u saturating +1 if prediction_o == br_result_i, else -1 (0..3).
  - Tagged, provider_i=1 with no tag hit: no update.
  - Tagged, alloc_i=1 and provider_i=0: only allowed when u==0.
    - Sets valid=1, tag=lat_tag, u=0.
    - Sets ctr=4 if taken, else 3.
    - If u != 0, the allocation is refused and u is decremented by 1 instead.
  - alloc_i and provider_i both 1: provider update wins, alloc_i ignored.
  - update_valid_i=0: storage unchanged; lookup still advances.
- Write and lookup of the same index in the same cycle: the next-cycle outputs show the post-update entry (storage is written at the edge, read combinationally from lat_idx afterwards).
- Index wrap: the index is taken modulo 2^IDX_W by width; no out-of-range case exists.

Optional Feature:
- Macro: TAGE_U_RESET_EN (tagged tables only).
- Defined:
  - A U_RESET_LOG2-bit counter increments on every update_valid_i.
  - On wrap it clears bit 1 of u in all entries; on the next wrap it clears bit 0; the two steps alternate.
  - This clearing occurs in the same edge as, and takes priority over, any u change in that edge.
  - The counter and the phase flag reset to 0.
- Undefined: u changes only through the update and allocation rules above; no counter is built.

Test Plan:
- Reset: assert rst_i mid-run, idx=5 presented -> prediction_o=0, tag_hit_o=0; bimodal table: prediction_o=0, tag_hit_o=1.
- Bimodal training: idx=7, three taken updates -> ctr 1->2->3, prediction_o=1 from the first update on; four not-taken updates -> ctr saturates at 0, prediction_o=0.
- Allocation: tagged table, idx=12, tag=0x2A5, alloc_i=1, taken -> next lookup of idx=12 with tag 0x2A5: tag_hit_o=1, prediction_o=1; same lookup with tag 0x2A4: tag_hit_o=0.
- Provider counter: allocated entry (ctr=4), provider_i=1, not taken x2 -> ctr 3 then 2, prediction_o=0; taken x6 -> saturates at 7.
- Useful bits: provider_i=1, update_u_i=1, correct x4 -> u=3 (saturates). A following alloc_i on that entry is refused, u=2, and tag is unchanged.
- TAGE_U_RESET_EN with U_RESET_LOG2=2: u=3; after 4 updates -> u=1; after 4 more -> u=0.
